// File: rtl/csr_sys_unit.sv
`default_nettype none
// ============================================================================
//  Module   : csr_sys_unit (plus package csr_sys_pkg)
//  Purpose  : Execution end of the FU_CSR path. Sequences CSR read/write/
//             set/clear, FENCE, FENCE_I, SFENCE_VMA, WFI and xRET ops against
//             the CSR file, store buffer, I-cache and TLB. It returns exactly
//             one writeback per accepted op, optionally with an exception.
//  Ports    : clk_i/rst_i      clock and synchronous active-high reset
//             flush_i          kills the in-flight op with no writeback
//             issue_*          op handshake from the issue stage
//             csr_*            single-cycle CSR file access
//             sb_*             store-buffer drain request and status
//             icache_*         I-cache invalidate pulse and done
//             tlb_*            TLB flush pulse with vaddr and asid
//             irq_pending_i    WFI wake-up
//             eret_*           xRET notification on writeback
//             wb_*             result channel (valid/ready)
//  Revision : 1.0 - initial release
// ============================================================================

package csr_sys_pkg;
  typedef enum logic [3:0] {
    CSR_READ   = 4'd0,
    CSR_WRITE  = 4'd1,
    CSR_SET    = 4'd2,
    CSR_CLEAR  = 4'd3,
    FENCE      = 4'd4,
    FENCE_I    = 4'd5,
    SFENCE_VMA = 4'd6,
    WFI        = 4'd7,
    MRET       = 4'd8,
    SRET       = 4'd9,
    DRET       = 4'd10
  } fu_op_t;
endpackage

module csr_sys_unit
  import csr_sys_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int TRANS_ID_W = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [1:0]            priv_i,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  fu_op_t                op_i,
  input  logic [XLEN-1:0]       operand1_i,
  input  logic [XLEN-1:0]       operand2_i,
  input  logic [TRANS_ID_W-1:0] trans_id_i,
  output logic                  csr_re_o,
  output logic                  csr_we_o,
  output logic [11:0]           csr_addr_o,
  output logic [XLEN-1:0]       csr_wdata_o,
  input  logic [XLEN-1:0]       csr_rdata_i,
  input  logic                  csr_err_i,
  output logic                  sb_drain_o,
  input  logic                  sb_empty_i,
  output logic                  icache_flush_o,
  input  logic                  icache_flush_done_i,
  output logic                  tlb_flush_o,
  output logic [XLEN-1:0]       tlb_vaddr_o,
  output logic [XLEN-1:0]       tlb_asid_o,
  input  logic                  irq_pending_i,
  output logic                  eret_o,
  output fu_op_t                eret_op_o,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [TRANS_ID_W-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]       wb_data_o,
  output logic                  wb_ex_valid_o,
  output logic [XLEN-1:0]       wb_ex_cause_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CSR_RW   = 3'd1;
  localparam logic [2:0] S_DRAIN    = 3'd2;
  localparam logic [2:0] S_ICFLUSH  = 3'd3;
  localparam logic [2:0] S_WFI_WAIT = 3'd4;
  localparam logic [2:0] S_RESP     = 3'd5;

  localparam logic [XLEN-1:0] C_CAUSE_ILLEGAL = XLEN'(2);

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  fu_op_t                r_op;
  logic [XLEN-1:0]       r_op1;
  logic [11:0]           r_addr;
  logic [TRANS_ID_W-1:0] r_trans_id;
  logic [XLEN-1:0]       r_wb_data;
  logic                  r_ex_valid;

  logic                  w_accept;
  logic                  w_known_op;
  logic                  w_in_csr;
  logic                  w_write_en;
  logic                  w_illegal;
  logic                  w_is_xret;
  logic                  w_wb_valid;
  logic                  w_handshake;
  logic [XLEN-1:0]       w_wdata;

  // A flush in IDLE blocks acceptance so the offered op is simply dropped.
  assign w_accept = (r_state == S_IDLE) && issue_valid_i && !flush_i;

  always_comb begin
    w_known_op = 1'b1;
    case (op_i)
      CSR_READ, CSR_WRITE, CSR_SET, CSR_CLEAR,
      FENCE, FENCE_I, SFENCE_VMA, WFI,
      MRET, SRET, DRET: w_known_op = 1'b1;
      default:          w_known_op = 1'b0;
    endcase
  end

  // CSR access checks: read-only space only matters for writes, while the
  // privilege field and a nonexistent CSR make any access illegal.
  assign w_in_csr   = (r_state == S_CSR_RW) && !flush_i;
  assign w_write_en = (r_op != CSR_READ);
  assign w_illegal  = (w_write_en && (r_addr[11:10] == 2'b11))
                    || (r_addr[9:8] > priv_i)
                    || csr_err_i;

  always_comb begin
    w_wdata = '0;
    case (r_op)
      CSR_WRITE: w_wdata = r_op1;
      CSR_SET:   w_wdata = csr_rdata_i | r_op1;
      CSR_CLEAR: w_wdata = csr_rdata_i & ~r_op1;
      default:   w_wdata = '0;
    endcase
  end

  assign w_is_xret   = (r_op == MRET) || (r_op == SRET) || (r_op == DRET);
  assign w_wb_valid  = (r_state == S_RESP) && !flush_i;
  assign w_handshake = w_wb_valid && wb_ready_i;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (op_i)
            CSR_READ, CSR_WRITE, CSR_SET, CSR_CLEAR: w_next = S_CSR_RW;
            FENCE, FENCE_I:                          w_next = S_DRAIN;
            WFI:                                     w_next = S_WFI_WAIT;
            default:                                 w_next = S_RESP;
          endcase
        end
      end
      S_CSR_RW:   w_next = S_RESP;
      S_DRAIN: begin
        if (sb_empty_i) begin
          w_next = (r_op == FENCE_I) ? S_ICFLUSH : S_RESP;
        end
      end
      S_ICFLUSH:  if (icache_flush_done_i) w_next = S_RESP;
      S_WFI_WAIT: if (irq_pending_i)       w_next = S_RESP;
      S_RESP:     if (wb_ready_i)          w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_op       <= CSR_READ;
      r_op1      <= '0;
      r_addr     <= '0;
      r_trans_id <= '0;
      r_wb_data  <= '0;
      r_ex_valid <= 1'b0;
    end else if (flush_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op       <= op_i;
        r_op1      <= operand1_i;
        r_addr     <= operand2_i[11:0];
        r_trans_id <= trans_id_i;
        r_wb_data  <= '0;
        // Undecodable ops still get a writeback, flagged illegal.
        r_ex_valid <= !w_known_op;
      end
      if (r_state == S_CSR_RW) begin
        r_wb_data  <= csr_rdata_i;
        r_ex_valid <= w_illegal;
      end
    end
  end

  assign issue_ready_o  = (r_state == S_IDLE);

  assign csr_re_o       = w_in_csr;
  assign csr_we_o       = w_in_csr && w_write_en && !w_illegal;
  assign csr_addr_o     = w_in_csr ? r_addr : 12'd0;
  assign csr_wdata_o    = csr_we_o ? w_wdata : '0;

  assign sb_drain_o     = (r_state == S_DRAIN) && !flush_i;
  assign icache_flush_o = sb_drain_o && sb_empty_i && (r_op == FENCE_I);

  // SFENCE_VMA fires straight from the accept cycle, so it uses the live operands.
  assign tlb_flush_o    = w_accept && (op_i == SFENCE_VMA);
  assign tlb_vaddr_o    = tlb_flush_o ? operand1_i : '0;
  assign tlb_asid_o     = tlb_flush_o ? operand2_i : '0;

  assign eret_o         = w_handshake && w_is_xret;
  assign eret_op_o      = eret_o ? r_op : CSR_READ;

  assign wb_valid_o     = w_wb_valid;
  assign wb_trans_id_o  = w_wb_valid ? r_trans_id : '0;
  assign wb_data_o      = w_wb_valid ? r_wb_data : '0;
  assign wb_ex_valid_o  = w_wb_valid && r_ex_valid;
  assign wb_ex_cause_o  = (w_wb_valid && r_ex_valid) ? C_CAUSE_ILLEGAL : '0;

endmodule
`default_nettype wire

// File: tb/tb_csr_sys_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_sys_unit
//  Purpose  : Directed self-checking bench for csr_sys_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csr_sys_unit;
  import csr_sys_pkg::*;

  localparam int XLEN = 64;
  localparam int TIDW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic [1:0]      priv = 2'd3;
  logic            issue_valid = 1'b0;
  logic            issue_ready;
  fu_op_t          op = CSR_READ;
  logic [XLEN-1:0] op1 = '0;
  logic [XLEN-1:0] op2 = '0;
  logic [TIDW-1:0] tid = '0;
  logic            csr_re, csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata = '0;
  logic            csr_err = 1'b0;
  logic            sb_drain;
  logic            sb_empty = 1'b1;
  logic            ic_flush;
  logic            ic_done = 1'b0;
  logic            tlb_flush;
  logic [XLEN-1:0] tlb_vaddr, tlb_asid;
  logic            irq = 1'b0;
  logic            eret;
  fu_op_t          eret_op;
  logic            wb_valid;
  logic            wb_ready = 1'b0;
  logic [TIDW-1:0] wb_tid;
  logic [XLEN-1:0] wb_data;
  logic            wb_ex;
  logic [XLEN-1:0] wb_cause;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_sys_unit #(.XLEN(XLEN), .TRANS_ID_W(TIDW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .priv_i(priv),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .op_i(op), .operand1_i(op1), .operand2_i(op2), .trans_id_i(tid),
    .csr_re_o(csr_re), .csr_we_o(csr_we), .csr_addr_o(csr_addr),
    .csr_wdata_o(csr_wdata), .csr_rdata_i(csr_rdata), .csr_err_i(csr_err),
    .sb_drain_o(sb_drain), .sb_empty_i(sb_empty),
    .icache_flush_o(ic_flush), .icache_flush_done_i(ic_done),
    .tlb_flush_o(tlb_flush), .tlb_vaddr_o(tlb_vaddr), .tlb_asid_o(tlb_asid),
    .irq_pending_i(irq), .eret_o(eret), .eret_op_o(eret_op),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_trans_id_o(wb_tid),
    .wb_data_o(wb_data), .wb_ex_valid_o(wb_ex), .wb_ex_cause_o(wb_cause)
  );

  // Inputs change 1ns after the rising edge; checks follow 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input fu_op_t o, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TIDW-1:0] t);
    issue_valid = 1'b1; op = o; op1 = a; op2 = b; tid = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", issue_ready); end
    checks++; if ({csr_re, csr_we, sb_drain, ic_flush, tlb_flush, eret, wb_valid, wb_ex} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got %b exp 00000000", {csr_re, csr_we, sb_drain, ic_flush, tlb_flush, eret, wb_valid, wb_ex});
    end
    checks++; if (wb_data !== '0) begin errors++; $display("FAIL reset_wbdata: got %h exp 0", wb_data); end
  endtask

  // One CSR op from accept to writeback with hand-computed expectations.
  task automatic test_csr(input string name, input fu_op_t o, input logic [11:0] addr,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] rdata,
                          input logic err, input logic [1:0] pl, input logic exp_we,
                          input logic [XLEN-1:0] exp_wdata, input logic exp_ex);
    priv = pl;
    offer(o, a, {52'd0, addr}, 3'd5);
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b exp 1", name, issue_ready); end
    tick();
    issue_valid = 1'b0; csr_rdata = rdata; csr_err = err;
    #1;
    checks++; if (csr_re !== 1'b1 || csr_addr !== addr) begin
      errors++; $display("FAIL %s_re: got re=%b addr=%h exp re=1 addr=%h", name, csr_re, csr_addr, addr);
    end
    checks++; if (csr_we !== exp_we || (exp_we && csr_wdata !== exp_wdata)) begin
      errors++; $display("FAIL %s_we: got we=%b wdata=%h exp we=%b wdata=%h", name, csr_we, csr_wdata, exp_we, exp_wdata);
    end
    tick();
    csr_rdata = '0; csr_err = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b1 || wb_tid !== 3'd5 || wb_data !== rdata) begin
      errors++; $display("FAIL %s_wb: got v=%b id=%0d data=%h exp v=1 id=5 data=%h", name, wb_valid, wb_tid, wb_data, rdata);
    end
    checks++; if (wb_ex !== exp_ex || wb_cause !== (exp_ex ? 64'd2 : 64'd0)) begin
      errors++; $display("FAIL %s_ex: got ex=%b cause=%0d exp ex=%b", name, wb_ex, wb_cause, exp_ex);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    priv = 2'd3;
  endtask

  task automatic test_fence_i();
    int pulses = 0;
    sb_empty = 1'b0;
    offer(FENCE_I, '0, '0, 3'd2);
    tick();
    issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb_empty = (i == 3);
      #1;
      if (ic_flush === 1'b1) pulses++;
      checks++; if (sb_drain !== 1'b1) begin errors++; $display("FAIL fencei_drain%0d: got %b exp 1", i, sb_drain); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      ic_done = (i == 1);
      #1;
      if (ic_flush === 1'b1) pulses++;
      checks++; if (sb_drain !== 1'b0 || wb_valid !== 1'b0) begin
        errors++; $display("FAIL fencei_icwait%0d: got drain=%b wbv=%b exp 0 0", i, sb_drain, wb_valid);
      end
      tick();
    end
    ic_done = 1'b0;
    #1;
    checks++; if (pulses != 1) begin errors++; $display("FAIL fencei_pulses: got %0d exp 1", pulses); end
    checks++; if (wb_valid !== 1'b1 || wb_ex !== 1'b0 || wb_data !== '0) begin
      errors++; $display("FAIL fencei_wb: got v=%b ex=%b data=%h exp 1 0 0", wb_valid, wb_ex, wb_data);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_fence_empty();
    sb_empty = 1'b1;
    offer(FENCE, '0, '0, 3'd1);
    tick();
    issue_valid = 1'b0;
    #1;
    checks++; if (sb_drain !== 1'b1 || ic_flush !== 1'b0) begin
      errors++; $display("FAIL fence_drain: got drain=%b icf=%b exp 1 0", sb_drain, ic_flush);
    end
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_tid !== 3'd1) begin
      errors++; $display("FAIL fence_wb: got v=%b id=%0d exp 1 1", wb_valid, wb_tid);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_wfi();
    int early = 0;
    irq = 1'b0;
    offer(WFI, '0, '0, 3'd6);
    tick();
    issue_valid = 1'b0;
    for (int c = 1; c < 10; c++) begin
      #1;
      if (wb_valid !== 1'b0) early++;
      tick();
    end
    irq = 1'b1;
    tick();
    irq = 1'b0;
    checks++; if (early != 0) begin errors++; $display("FAIL wfi_early: got %0d early valid cycles exp 0", early); end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (wb_valid !== 1'b1 || wb_ex !== 1'b0 || wb_tid !== 3'd6 || wb_data !== '0) begin
        errors++; $display("FAIL wfi_hold%0d: got v=%b ex=%b id=%0d data=%h exp 1 0 6 0", k, wb_valid, wb_ex, wb_tid, wb_data);
      end
      tick();
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL wfi_idle: got %b exp 1", issue_ready); end
  endtask

  task automatic test_sfence();
    offer(SFENCE_VMA, 64'hAAAA_0000_1234, 64'h55, 3'd3);
    #1;
    checks++; if (tlb_flush !== 1'b1 || tlb_vaddr !== 64'hAAAA_0000_1234 || tlb_asid !== 64'h55) begin
      errors++; $display("FAIL sfence_pulse: got f=%b va=%h asid=%h exp 1 aaaa00001234 55", tlb_flush, tlb_vaddr, tlb_asid);
    end
    tick();
    issue_valid = 1'b0;
    #1;
    checks++; if (tlb_flush !== 1'b0 || wb_valid !== 1'b1 || eret !== 1'b0) begin
      errors++; $display("FAIL sfence_wb: got f=%b v=%b eret=%b exp 0 1 0", tlb_flush, wb_valid, eret);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    offer(MRET, '0, '0, 3'd4);
    tick();
    offer(SRET, '0, '0, 3'd7);
    wb_ready = 1'b1;
    #1;
    checks++; if (eret !== 1'b1 || eret_op !== MRET) begin
      errors++; $display("FAIL mret_eret: got eret=%b op=%0d exp 1 %0d", eret, eret_op, MRET);
    end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready: got %b exp 0", issue_ready); end
    tick();
    wb_ready = 1'b0;
    #1;
    checks++; if (issue_ready !== 1'b1 || eret !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: got ready=%b eret=%b exp 1 0", issue_ready, eret);
    end
    tick();
    issue_valid = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b1 || wb_tid !== 3'd7) begin
      errors++; $display("FAIL b2b_wb: got v=%b id=%0d exp 1 7", wb_valid, wb_tid);
    end
    wb_ready = 1'b1;
    #1;
    checks++; if (eret !== 1'b1 || eret_op !== SRET) begin
      errors++; $display("FAIL sret_eret: got eret=%b op=%0d exp 1 %0d", eret, eret_op, SRET);
    end
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_flush();
    offer(MRET, '0, '0, 3'd4);
    tick();
    issue_valid = 1'b0;
    flush = 1'b1; wb_ready = 1'b1;
    #1;
    checks++; if (wb_valid !== 1'b0 || eret !== 1'b0) begin
      errors++; $display("FAIL flush_resp: got v=%b eret=%b exp 0 0", wb_valid, eret);
    end
    tick();
    flush = 1'b0; wb_ready = 1'b0;
    #1;
    checks++; if (issue_ready !== 1'b1 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle: got ready=%b v=%b exp 1 0", issue_ready, wb_valid);
    end
    offer(CSR_WRITE, 64'h1, 64'h300, 3'd2);
    tick();
    issue_valid = 1'b0; flush = 1'b1;
    #1;
    checks++; if (csr_we !== 1'b0 || csr_re !== 1'b0) begin
      errors++; $display("FAIL flush_csr: got we=%b re=%b exp 0 0", csr_we, csr_re);
    end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (issue_ready !== 1'b1 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL flush_csr_idle: got ready=%b v=%b exp 1 0", issue_ready, wb_valid);
    end
    // Flush together with an offer in IDLE: nothing is accepted.
    offer(SFENCE_VMA, 64'h10, 64'h1, 3'd1);
    flush = 1'b1;
    #1;
    checks++; if (tlb_flush !== 1'b0) begin errors++; $display("FAIL flush_offer_tlb: got %b exp 0", tlb_flush); end
    tick();
    issue_valid = 1'b0; flush = 1'b0;
    #1;
    checks++; if (issue_ready !== 1'b1 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL flush_offer_idle: got ready=%b v=%b exp 1 0", issue_ready, wb_valid);
    end
  endtask

  task automatic test_reset_mid();
    sb_empty = 1'b0;
    offer(FENCE, '0, '0, 3'd3);
    tick();
    issue_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (sb_drain !== 1'b0 || issue_ready !== 1'b1 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got drain=%b ready=%b v=%b exp 0 1 0", sb_drain, issue_ready, wb_valid);
    end
    sb_empty = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_csr("csrrs", CSR_SET, 12'h300, 64'h8, 64'h1800, 1'b0, 2'd3, 1'b1, 64'h1808, 1'b0);
    test_csr("csrrc", CSR_CLEAR, 12'h340, 64'h0F, 64'hFF, 1'b0, 2'd3, 1'b1, 64'hF0, 1'b0);
    test_csr("csrrw_ro", CSR_WRITE, 12'hC00, 64'hFF, 64'h1234, 1'b0, 2'd3, 1'b0, 64'h0, 1'b1);
    test_csr("csrr_ro", CSR_READ, 12'hC00, 64'h0, 64'h77, 1'b0, 2'd0, 1'b0, 64'h0, 1'b0);
    test_csr("csrr_upriv", CSR_READ, 12'h300, 64'h0, 64'h99, 1'b0, 2'd0, 1'b0, 64'h0, 1'b1);
    test_csr("csrr_err", CSR_READ, 12'h305, 64'h0, 64'h5, 1'b1, 2'd3, 1'b0, 64'h0, 1'b1);
    test_fence_i();
    test_fence_empty();
    test_wfi();
    test_sfence();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish exp finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/csr_sys_unit.md
Name: csr_sys_unit

Overview:
- Execution end of the FU_CSR path. Consumes the scoreboard entries that decode marks FU_CSR: CSR_READ/WRITE/SET/CLEAR, FENCE, FENCE_I, SFENCE_VMA, WFI, MRET, SRET, DRET.
- Sequences each op through a small FSM against the CSR register file, store buffer, I-cache and TLB.
- Returns one writeback, optionally carrying an exception, per accepted op.
- Sits between the issue stage and the commit/writeback bus.

Parameters:
- XLEN, 64, datapath width (matches RV_XLEN).
- TRANS_ID_W, 3, scoreboard transaction-id width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  kill in-flight op; no writeback.
- priv_i  in  2  current privilege level (priv_lvl_t).
- issue_valid_i  in  1  op offered.
- issue_ready_o  out  1  unit idle and able to accept.
- op_i  in  fu_op_t  decoded op.
- operand1_i  in  XLEN  rs1 value or zero-extended uimm.
- operand2_i  in  XLEN  CSR address in [11:0]; rs2 value for SFENCE_VMA.
- trans_id_i  in  TRANS_ID_W  scoreboard id.
- csr_re_o  out  1  CSR read strobe.
- csr_we_o  out  1  CSR write strobe.
- csr_addr_o  out  12  CSR address.
- csr_wdata_o  out  XLEN  CSR write data.
- csr_rdata_i  in  XLEN  read data, combinational, same cycle as csr_re_o.
- csr_err_i  in  1  nonexistent CSR, same cycle as csr_re_o.
- sb_drain_o  out  1  request store-buffer drain.
- sb_empty_i  in  1  store buffer empty.
- icache_flush_o  out  1  one-cycle I-cache invalidate pulse.
- icache_flush_done_i  in  1  invalidate complete.
- tlb_flush_o  out  1  one-cycle TLB flush pulse.
- tlb_vaddr_o  out  XLEN  SFENCE vaddr (operand1).
- tlb_asid_o  out  XLEN  SFENCE asid (operand2).
- irq_pending_i  in  1  any enabled interrupt pending.
- eret_o  out  1  one-cycle pulse on xRET writeback.
- eret_op_o  out  fu_op_t  which xRET.
- wb_valid_o  out  1  result valid.
- wb_ready_i  in  1  writeback accepted.
- wb_trans_id_o  out  TRANS_ID_W  id of result.
- wb_data_o  out  XLEN  old CSR value (CSR ops), else 0.
- wb_ex_valid_o  out  1  exception flag.
- wb_ex_cause_o  out  XLEN  exception cause; 2 = illegal instruction.

Behaviour:
- Reset: state IDLE; all outputs 0 except issue_ready_o=1.
- Accept: op, operands and trans_id are latched when issue_valid_i && issue_ready_o.
- issue_ready_o=1 only in IDLE. One op is in flight at a time.
- FSM states: IDLE, CSR_RW, DRAIN, ICFLUSH, WFI_WAIT, RESP.
- IDLE on accept:
  - CSR op -> CSR_RW.
  - FENCE, FENCE_I -> DRAIN.
  - WFI -> WFI_WAIT.
  - SFENCE_VMA: tlb_flush_o pulses in the accept cycle, then -> RESP.
  - MRET, SRET, DRET -> RESP.
- CSR_RW, one cycle:
  - csr_re_o=1, csr_addr_o=latched addr.
  - Write enabled when op != CSR_READ.
  - Write is illegal if addr[11:10]==2'b11 (read-only CSR).
  - Access is illegal if addr[9:8] > priv_i, or if csr_err_i=1.
  - If not illegal and write enabled: csr_we_o=1, csr_wdata_o as follows:
    - WRITE: op1.
    - SET: rdata | op1.
    - CLEAR: rdata & ~op1.
  - If illegal: csr_we_o=0 and the exception is set (cause 2).
  - wb_data_o captures csr_rdata_i. -> RESP.
- CSR latency: accept at cycle N, CSR access at N+1, wb_valid_o at N+2.
- DRAIN: sb_drain_o=1 until sb_empty_i.
  - FENCE -> RESP.
  - FENCE_I -> ICFLUSH, with icache_flush_o pulsed on the exit cycle.
  - If sb_empty_i is already 1 on entry, DRAIN lasts one cycle.
- ICFLUSH: wait for icache_flush_done_i, then -> RESP.
- WFI_WAIT: stay until irq_pending_i=1, then -> RESP. WFI always completes normally, with no exception.
- RESP:
  - wb_valid_o held with stable data until wb_ready_i, then -> IDLE.
  - eret_o pulses in the handshake cycle for xRET ops.
  - No back-to-back accept in the handshake cycle: the next accept is earliest the following cycle.
- flush_i (any state, including RESP): next state IDLE.
  - All strobes deasserted in that same cycle; csr_we_o suppressed even in CSR_RW.
  - No wb_valid_o or eret_o.
- flush_i has priority over all other transitions. rst_i has priority over flush_i.
- flush_i arriving together with issue_valid_i in IDLE: the op is not accepted.
- Reset mid-operation: abandons the op with no writeback, strobes 0 from the next cycle.

Test Plan:
- CSRRS, addr 0x300, op1=0x8, csr_rdata_i=0x1800, priv=M:
  - csr_we_o=1, csr_wdata_o=0x1808 at N+1.
  - wb_data_o=0x1800, wb_ex_valid_o=0 at N+2.
- CSRRW to 0xC00 (read-only):
  - csr_we_o=0.
  - wb_ex_valid_o=1, cause=2, wb_data_o=rdata.
- CSR_READ of 0x300 at priv=U: illegal, cause=2.
- CSR_READ of 0x305 at priv=M with csr_err_i=1: illegal, cause=2.
- FENCE_I with sb_empty_i low for 3 cycles, then icache_flush_done_i after 2 further cycles:
  - sb_drain_o high for 4 cycles.
  - Single icache_flush_o pulse.
  - wb_valid_o the cycle after done.
- WFI with irq_pending_i rising at cycle 10:
  - WFI_WAIT holds until then; wb_valid_o at cycle 11, no exception.
  - Hold wb_ready_i=0 for 3 cycles: outputs stable.
- MRET, then flush_i asserted in RESP:
  - No eret_o, no wb handshake.
  - issue_ready_o=1 next cycle.
  - A following CSRRW gets no csr_we_o if flush_i is asserted during its CSR_RW cycle.
